// File: rtl/msrv32_rf_port_ctrl.sv
// msrv32_rf_port_ctrl
// Sequencer/arbiter in front of the integer register file write port and
// rs_2 read port. After reset an optional sweep zeroes x1..x(DEPTH-1) while
// the core is stalled. Afterwards core writeback owns the write port and a
// 4-phase debug port gets whatever the core leaves free. Debug reads borrow
// the rs_2 read port and are only started while the core is halted.
//
// Build option: define MSRV32_RF_INIT_EN to include the post-reset sweep.
// Without it reset goes straight to IDLE, init_busy_out is tied low and the
// register file itself is expected to clear on reset.
//
// state  | meaning
// INIT   | zero sweep in progress, one register per cycle, core stalled
// IDLE   | waiting for a debug request while the core is halted
// ACCESS | debug access; writes retry while core writeback holds the port
// ACK    | access done, dbg_ack_out high until dbg_req_in drops

module msrv32_rf_port_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  msrv32_mp_clk_in,
  input  logic                  msrv32_mp_rst_n_in,
  input  logic                  wb_wr_en_in,
  input  logic [ADDR_WIDTH-1:0] wb_rd_addr_in,
  input  logic [WIDTH-1:0]      wb_rd_in,
  input  logic [ADDR_WIDTH-1:0] core_rs_2_addr_in,
  input  logic                  core_halted_in,
  input  logic                  dbg_req_in,
  input  logic                  dbg_we_in,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_in,
  input  logic [WIDTH-1:0]      dbg_wdata_in,
  output logic                  dbg_ack_out,
  output logic [WIDTH-1:0]      dbg_rdata_out,
  output logic                  init_busy_out,
  output logic                  rf_wr_en_out,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr_out,
  output logic [WIDTH-1:0]      rf_rd_out,
  output logic [ADDR_WIDTH-1:0] rf_rs_2_addr_out,
  input  logic [WIDTH-1:0]      rf_rs_2_in
);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_t;

`ifdef MSRV32_RF_INIT_EN
  localparam state_t RESET_STATE = INIT;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t state;
  state_t state_next;
  logic   wr_en;

`ifdef MSRV32_RF_INIT_EN
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic                  sweep_last;

  assign sweep_last = (sweep_addr == ADDR_WIDTH'(DEPTH - 1));

  // Sweep address: starts at x1 on every reset, advances once per INIT cycle
  always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_n_in) begin
    if (!msrv32_mp_rst_n_in) begin
      sweep_addr <= ADDR_WIDTH'(1);
    end else if (state == INIT) begin
      sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
    end
  end

  assign init_busy_out = (state == INIT);
`else
  assign init_busy_out = 1'b0;
`endif

  // State register
  always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_n_in) begin
    if (!msrv32_mp_rst_n_in) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; halt is only looked at when deciding to start an access
  always_comb begin
    state_next = state;
    case (state)
      INIT: begin
`ifdef MSRV32_RF_INIT_EN
        if (sweep_last) state_next = IDLE;
`else
        state_next = IDLE;
`endif
      end
      IDLE: begin
        if (dbg_req_in && core_halted_in) state_next = ACCESS;
      end
      ACCESS: begin
        if (!dbg_we_in || !wb_wr_en_in) state_next = ACK;
      end
      ACK: begin
        if (!dbg_req_in) state_next = IDLE;
      end
      default: state_next = RESET_STATE;
    endcase
  end

  // Port muxing: sweep, else core writeback, else a pending debug write;
  // x0 is never written, and nothing is written while reset is held
  always_comb begin
    wr_en            = 1'b0;
    rf_rd_addr_out   = wb_rd_addr_in;
    rf_rd_out        = wb_rd_in;
    rf_rs_2_addr_out = core_rs_2_addr_in;
    if (state == INIT) begin
`ifdef MSRV32_RF_INIT_EN
      wr_en          = 1'b1;
      rf_rd_addr_out = sweep_addr;
      rf_rd_out      = '0;
`endif
    end else if (wb_wr_en_in) begin
      wr_en = (wb_rd_addr_in != '0);
    end else if ((state == ACCESS) && dbg_we_in) begin
      wr_en          = (dbg_addr_in != '0);
      rf_rd_addr_out = dbg_addr_in;
      rf_rd_out      = dbg_wdata_in;
    end
    if ((state == ACCESS) && !dbg_we_in) begin
      rf_rs_2_addr_out = dbg_addr_in;
    end
  end

  assign rf_wr_en_out = wr_en & msrv32_mp_rst_n_in;

  // Debug handshake outputs: ack follows entry into ACK, read data captured
  // at the end of a read ACCESS cycle and held until the next read
  always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_n_in) begin
    if (!msrv32_mp_rst_n_in) begin
      dbg_ack_out   <= 1'b0;
      dbg_rdata_out <= '0;
    end else begin
      dbg_ack_out <= (state_next == ACK);
      if ((state == ACCESS) && !dbg_we_in) begin
        dbg_rdata_out <= rf_rs_2_in;
      end
    end
  end

endmodule
